// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares one register file between two requesters, A (CPU datapath) and
//   B (debug/loader). Each request is either a two-operand read or a
//   single-register write. It completes with a one-cycle ACK. When both
//   requesters are waiting, round-robin arbitration picks the winner.
//   Every register-file-side output is registered.
//
//   Transaction timeline (REQ seen in IDLE at cycle 0):
//     write : RF_WRITE in cycle 1, ACK in cycle 2
//     read  : RF_READ in cycles 1-2, data captured at the end of cycle 2,
//             ACK with the data visible in cycle 3
//
// Ports
//   CLK, RST                  clock and synchronous active-high reset
//   A_*/B_* REQ, WE           request (held until ACK), 1 = write / 0 = read
//   A_*/B_* ADDR_R1/R2/W      operand and destination register addresses
//   A_*/B_* DATA_W            write data
//   A_ACK/B_ACK               one-cycle completion pulse
//   A_*/B_* DATA_R1/R2        captured read data, held until that side's next read
//   RF_READ, RF_WRITE         register file strobes (never both high)
//   RF_ADDR_R1/R2/W           register file addresses
//   RF_DATA_W                 register file write data
//   RF_DATA_R1/R2             register file read data (floating while RF_READ=0)
//   BUSY                      high whenever the arbiter is not idle
module rf_port_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_W,
  input  logic [DATA_WIDTH-1:0] A_DATA_W,
  output logic                  A_ACK,
  output logic [DATA_WIDTH-1:0] A_DATA_R1,
  output logic [DATA_WIDTH-1:0] A_DATA_R2,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] B_ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] B_ADDR_W,
  input  logic [DATA_WIDTH-1:0] B_DATA_W,
  output logic                  B_ACK,
  output logic [DATA_WIDTH-1:0] B_DATA_R1,
  output logic [DATA_WIDTH-1:0] B_DATA_R2,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_nxt;

  logic last_b;   // 1: B received the most recent grant
  logic win_b;    // winner of the transaction in flight
  logic we_l;     // latched write-enable of the transaction in flight

  logic                  grant;
  logic                  grant_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr_w;
  logic                  rf_read_nxt;
  logic                  rf_write_nxt;

  // A write to register 0 is acknowledged but kept off the file when protection is on.
  function automatic logic write_reaches_file(input logic [ADDR_WIDTH-1:0] addr);
    return !(ZERO_REG_PROTECT && (addr == '0));
  endfunction

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_b   = 1'b0;
    unique case (state)
      IDLE: begin
        if (A_REQ || B_REQ) begin
          grant     = 1'b1;
          // B wins when alone, or when both wait and A was served last.
          grant_b   = B_REQ && (!A_REQ || !last_b);
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = we_l ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // The strobes are registered, so they are derived from the state being
    // entered together with the fields being latched on this edge.
    sel_we       = grant ? (grant_b ? B_WE : A_WE) : we_l;
    sel_addr_w   = grant ? (grant_b ? B_ADDR_W : A_ADDR_W) : RF_ADDR_W;
    rf_read_nxt  = ((state_nxt == ISSUE) && !sel_we) || (state_nxt == CAPTURE);
    rf_write_nxt = (state_nxt == ISSUE) && sel_we && write_reaches_file(sel_addr_w);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      win_b      <= 1'b0;
      we_l       <= 1'b0;
      RF_READ    <= 1'b0;
      RF_WRITE   <= 1'b0;
      RF_ADDR_R1 <= '0;
      RF_ADDR_R2 <= '0;
      RF_ADDR_W  <= '0;
      RF_DATA_W  <= '0;
      A_ACK      <= 1'b0;
      B_ACK      <= 1'b0;
      BUSY       <= 1'b0;
      A_DATA_R1  <= '0;
      A_DATA_R2  <= '0;
      B_DATA_R1  <= '0;
      B_DATA_R2  <= '0;
    end else begin
      state    <= state_nxt;
      RF_READ  <= rf_read_nxt;
      RF_WRITE <= rf_write_nxt;
      BUSY     <= (state_nxt != IDLE);
      A_ACK    <= (state_nxt == RESP) && !win_b;
      B_ACK    <= (state_nxt == RESP) && win_b;

      // Grant: latch the winner's request; the RF pins double as the latch.
      if (grant) begin
        win_b      <= grant_b;
        last_b     <= grant_b;
        we_l       <= sel_we;
        RF_ADDR_R1 <= grant_b ? B_ADDR_R1 : A_ADDR_R1;
        RF_ADDR_R2 <= grant_b ? B_ADDR_R2 : A_ADDR_R2;
        RF_ADDR_W  <= sel_addr_w;
        RF_DATA_W  <= grant_b ? B_DATA_W : A_DATA_W;
      end

      // Capture: file data is valid on the second READ cycle.
      if (state == CAPTURE) begin
        if (win_b) begin
          B_DATA_R1 <= RF_DATA_R1;
          B_DATA_R2 <= RF_DATA_R2;
        end else begin
          A_DATA_R1 <= RF_DATA_R1;
          A_DATA_R2 <= RF_DATA_R2;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
module tb_rf_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          A_REQ, A_WE, B_REQ, B_WE;
  logic [AW-1:0] A_ADDR_R1, A_ADDR_R2, A_ADDR_W;
  logic [AW-1:0] B_ADDR_R1, B_ADDR_R2, B_ADDR_W;
  logic [DW-1:0] A_DATA_W, B_DATA_W;
  logic          A_ACK, B_ACK;
  logic [DW-1:0] A_DATA_R1, A_DATA_R2, B_DATA_R1, B_DATA_R2;
  logic          RF_READ, RF_WRITE, BUSY;
  logic [AW-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [DW-1:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;

  rf_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG_PROTECT(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR_R1(A_ADDR_R1), .A_ADDR_R2(A_ADDR_R2),
    .A_ADDR_W(A_ADDR_W), .A_DATA_W(A_DATA_W), .A_ACK(A_ACK),
    .A_DATA_R1(A_DATA_R1), .A_DATA_R2(A_DATA_R2),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR_R1(B_ADDR_R1), .B_ADDR_R2(B_ADDR_R2),
    .B_ADDR_W(B_ADDR_W), .B_DATA_W(B_DATA_W), .B_ACK(B_ACK),
    .B_DATA_R1(B_DATA_R1), .B_DATA_R2(B_DATA_R2),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
    .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Register file attached to the DUT; a poison word stands in for the floating bus.
  logic [DW-1:0] mem      [32];
  logic [DW-1:0] init_val [32];
  logic          preload;

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val[i];
    end else if (RF_WRITE) begin
      mem[RF_ADDR_W] <= RF_DATA_W;
    end
  end

  assign RF_DATA_R1 = RF_READ ? mem[RF_ADDR_R1] : 32'hBAD0_BAD0;
  assign RF_DATA_R2 = RF_READ ? mem[RF_ADDR_R2] : 32'hBAD0_BAD0;

  // Transaction-level reference: architectural register contents, expected
  // read-data outputs per requester, and the requester served last.
  logic [DW-1:0] ref_rf [32];
  logic [DW-1:0] exp_a1, exp_a2, exp_b1, exp_b2;
  bit            last_b;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag);
    chk({tag, "_a_r1"}, A_DATA_R1, exp_a1);
    chk({tag, "_a_r2"}, A_DATA_R2, exp_a2);
    chk({tag, "_b_r1"}, B_DATA_R1, exp_b1);
    chk({tag, "_b_r2"}, B_DATA_R2, exp_b2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_acks"},    32'({A_ACK, B_ACK}), 0);
    chk({tag, "_strobes"}, 32'({RF_READ, RF_WRITE}), 0);
    chk({tag, "_busy"},    32'(BUSY), 0);
    chk({tag, "_addrs"},   32'({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}), 0);
    chk({tag, "_data_w"},  RF_DATA_W, 0);
    check_data(tag);
  endtask

  task automatic model_reset();
    exp_a1 = '0; exp_a2 = '0; exp_b1 = '0; exp_b2 = '0;
    last_b = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    A_REQ = 0; A_WE = 0; A_ADDR_R1 = 0; A_ADDR_R2 = 0; A_ADDR_W = 0; A_DATA_W = 0;
    B_REQ = 0; B_WE = 0; B_ADDR_R1 = 0; B_ADDR_R2 = 0; B_ADDR_W = 0; B_DATA_W = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One request from a single requester, started with the DUT idle.
  task automatic txn(input bit who, input bit we, input logic [AW-1:0] r1,
                     input logic [AW-1:0] r2, input logic [AW-1:0] w,
                     input logic [DW-1:0] d, input bit drop);
    if (!who) begin
      A_WE = we; A_ADDR_R1 = r1; A_ADDR_R2 = r2; A_ADDR_W = w; A_DATA_W = d; A_REQ = 1;
    end else begin
      B_WE = we; B_ADDR_R1 = r1; B_ADDR_R2 = r2; B_ADDR_W = w; B_DATA_W = d; B_REQ = 1;
    end
    @(posedge CLK); #1;
    if (drop) begin A_REQ = 0; B_REQ = 0; end
    chk("iss_busy",     32'(BUSY), 1);
    chk("iss_rf_write", 32'(RF_WRITE), 32'(we && (w != 0)));
    chk("iss_rf_read",  32'(RF_READ), 32'(!we));
    chk("iss_acks",     32'({A_ACK, B_ACK}), 0);
    if (we) begin
      chk("iss_addr_w", 32'(RF_ADDR_W), 32'(w));
      chk("iss_data_w", RF_DATA_W, d);
    end else begin
      chk("iss_addr_r", 32'({RF_ADDR_R1, RF_ADDR_R2}), 32'({r1, r2}));
      @(posedge CLK); #1;
      chk("cap_strobes", 32'({RF_READ, RF_WRITE}), 32'(2'b10));
      chk("cap_acks",    32'({A_ACK, B_ACK}), 0);
      chk("cap_addr_r",  32'({RF_ADDR_R1, RF_ADDR_R2}), 32'({r1, r2}));
    end
    @(posedge CLK); #1;
    A_REQ = 0; B_REQ = 0;
    last_b = who;
    if (we) begin
      if (w != 0) ref_rf[w] = d;
    end else if (!who) begin
      exp_a1 = ref_rf[r1]; exp_a2 = ref_rf[r2];
    end else begin
      exp_b1 = ref_rf[r1]; exp_b2 = ref_rf[r2];
    end
    chk("resp_a_ack",   32'(A_ACK), 32'(!who));
    chk("resp_b_ack",   32'(B_ACK), 32'(who));
    chk("resp_strobes", 32'({RF_READ, RF_WRITE}), 0);
    check_data("resp");
    @(posedge CLK); #1;
    chk("idle_acks", 32'({A_ACK, B_ACK}), 0);
    chk("idle_busy", 32'(BUSY), 0);
  endtask

  // Both requesters issue writes with REQ held high; grants must alternate.
  task automatic both_writes(input int n, input bit first);
    bit cur;
    cur = first;
    A_WE = 1; A_ADDR_W = AW'($urandom_range(1, 15));  A_DATA_W = $urandom;
    B_WE = 1; B_ADDR_W = AW'($urandom_range(16, 31)); B_DATA_W = $urandom;
    A_REQ = 1; B_REQ = 1;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      chk("rr_iss_write",  32'(RF_WRITE), 1);
      chk("rr_iss_addr_w", 32'(RF_ADDR_W), 32'(cur ? B_ADDR_W : A_ADDR_W));
      chk("rr_iss_data_w", RF_DATA_W, cur ? B_DATA_W : A_DATA_W);
      chk("rr_iss_acks",   32'({A_ACK, B_ACK}), 0);
      @(posedge CLK); #1;
      chk("rr_resp_acks", 32'({A_ACK, B_ACK}), cur ? 32'(2'b01) : 32'(2'b10));
      if (!cur) ref_rf[A_ADDR_W] = A_DATA_W;
      else      ref_rf[B_ADDR_W] = B_DATA_W;
      last_b = cur;
      if (k == n - 1) begin
        A_REQ = 0; B_REQ = 0;
      end else if (!cur) begin
        A_ADDR_W = AW'($urandom_range(1, 15));  A_DATA_W = $urandom;
      end else begin
        B_ADDR_W = AW'($urandom_range(16, 31)); B_DATA_W = $urandom;
      end
      @(posedge CLK); #1;
      chk("rr_idle_acks", 32'({A_ACK, B_ACK}), 0);
      chk("rr_idle_busy", 32'(BUSY), 0);
      cur = !cur;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    init_val[0] = '0;
    for (int i = 1; i < 32; i++) init_val[i] = $urandom;
    for (int i = 0; i < 32; i++) ref_rf[i] = init_val[i];
    preload = 1'b1;
    do_reset();
    preload = 1'b0;
    check_zero("reset");

    // Write then read back the same register from A.
    txn(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b0);
    chk("t1_a_r1", A_DATA_R1, 32'hDEADBEEF);
    chk("t1_a_r2", A_DATA_R2, 32'hDEADBEEF);

    // Contention straight out of reset: A first, then strict alternation.
    do_reset();
    check_zero("reset2");
    both_writes(6, !last_b);

    // Protected register 0.
    txn(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234, 1'b0);
    txn(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    chk("t3_r0", B_DATA_R1, 32'h0);

    // B read leaves A's captured data alone, and a REQ dropped after grant still completes.
    txn(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'hAAAA, 1'b0);
    txn(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0, 1'b1);
    chk("t5_a_r1", A_DATA_R1, 32'hAAAA);

    // Reset during CAPTURE abandons the read.
    A_WE = 0; A_ADDR_R1 = 5'd3; A_ADDR_R2 = 5'd9; A_REQ = 1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t4_cap_read", 32'(RF_READ), 1);
    RST = 1; A_REQ = 0;
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
    check_zero("t4_rst");
    both_writes(2, 1'b0);

    // Randomised single-requester traffic.
    repeat (40) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
          AW'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
    end
    both_writes(4, !last_b);

    // Whole file agrees with the reference after all traffic.
    for (int i = 0; i < 32; i++) begin
      chk("final_rf", mem[i], ref_rf[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
